// File: rtl/gpu_pkg.sv
// Shared pixel-pipeline constants: palette geometry, CPU register map
// and the RGB332 colour layout.
package gpu_pkg;

  localparam int INDEX_W = 9;
  localparam int COLOR_W = 8;
  localparam int CPU_W   = 16;

  localparam logic PAL_REG_PTR  = 1'b0;
  localparam logic PAL_REG_DATA = 1'b1;

  // RGB332: {R[2:0], G[2:0], B[1:0]}
  localparam int RGB_R_LSB = 5;
  localparam int RGB_R_W   = 3;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_G_W   = 3;
  localparam int RGB_B_LSB = 0;
  localparam int RGB_B_W   = 2;

  typedef struct packed {
    logic [RGB_R_W-1:0] r;
    logic [RGB_G_W-1:0] g;
    logic [RGB_B_W-1:0] b;
  } rgb332_t;

endpackage

// File: rtl/palette_lookup_if.sv
// Video and CPU signals of the palette stage; master drives indices and
// register accesses, slave is the palette block.
interface palette_lookup_if #(
  parameter int INDEX_W = gpu_pkg::INDEX_W,
  parameter int COLOR_W = gpu_pkg::COLOR_W
);
  import gpu_pkg::*;

  logic [INDEX_W-1:0] index_in;
  logic               active_in;
  logic               hsync_in;
  logic               vsync_in;
  logic [COLOR_W-1:0] rgb_out;
  logic               active_out;
  logic               hsync_out;
  logic               vsync_out;
  logic               mem_enable;
  logic               mem_write;
  logic               mem_addr;
  logic [CPU_W-1:0]   write_data;
  logic [CPU_W-1:0]   read_data;

  modport master (
    output index_in, active_in, hsync_in, vsync_in,
    output mem_enable, mem_write, mem_addr, write_data,
    input  rgb_out, active_out, hsync_out, vsync_out, read_data
  );

  modport slave (
    input  index_in, active_in, hsync_in, vsync_in,
    input  mem_enable, mem_write, mem_addr, write_data,
    output rgb_out, active_out, hsync_out, vsync_out, read_data
  );

endinterface

// File: rtl/palette_ram.sv
// Colour RAM: port A is the CPU read/write port, port B the video read port.
// Both reads are synchronous and read-first so the array maps to one block RAM.
module palette_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_rst_a,
  input  logic              i_we_a,
  input  logic              i_re_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_din_a,
  output logic [DATA_W-1:0] o_dout_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic [DATA_W-1:0] o_dout_b
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_dout_a;
  logic [DATA_W-1:0] r_dout_b;

  // Port A output only updates on reads so a CPU read result holds across writes.
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_din_a;
    if (i_rst_a) r_dout_a <= '0;
    else if (i_re_a) r_dout_a <= r_mem[i_addr_a];
  end

  always_ff @(posedge clk) begin
    r_dout_b <= r_mem[i_addr_b];
  end

  assign o_dout_a = r_dout_a;
  assign o_dout_b = r_dout_b;

endmodule

// File: rtl/palette_lookup.sv
// Palette index -> RGB332 lookup with a 2-cycle pixel pipeline, matching
// sync/blank delay, and a pointer/data CPU register pair into the colour RAM.
module palette_lookup #(
  parameter int INDEX_W = gpu_pkg::INDEX_W,
  parameter int COLOR_W = gpu_pkg::COLOR_W
) (
  input  logic             clk,
  input  logic             rst,
  palette_lookup_if.slave  bus
);
  import gpu_pkg::*;

  logic [INDEX_W-1:0] r_ptr;
  logic [INDEX_W-1:0] r_rd_ptr;
  logic               r_rd_sel;
  logic               r_active_d1;
  logic               r_hsync_d1;
  logic               r_vsync_d1;
  logic               r_active_d2;
  logic               r_hsync_d2;
  logic               r_vsync_d2;
  logic [COLOR_W-1:0] r_rgb;

  logic               w_cpu_wr;
  logic               w_cpu_rd;
  logic               w_wr_ptr;
  logic               w_wr_data;
  logic               w_rd_ptr;
  logic               w_rd_data;
  logic [COLOR_W-1:0] w_cpu_rdata;
  logic [COLOR_W-1:0] w_pix_color;
  logic               w_unused;

  // Accesses in a reset cycle are dropped so ptr comes out of reset at 0.
  always_comb begin
    w_cpu_wr  = bus.mem_enable & bus.mem_write & ~rst;
    w_cpu_rd  = bus.mem_enable & ~bus.mem_write & ~rst;
    w_wr_ptr  = w_cpu_wr & (bus.mem_addr == PAL_REG_PTR);
    w_wr_data = w_cpu_wr & (bus.mem_addr == PAL_REG_DATA);
    w_rd_ptr  = w_cpu_rd & (bus.mem_addr == PAL_REG_PTR);
    w_rd_data = w_cpu_rd & (bus.mem_addr == PAL_REG_DATA);
  end

  assign w_unused = ^bus.write_data[CPU_W-1:INDEX_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_wr_ptr) begin
      r_ptr <= bus.write_data[INDEX_W-1:0];
    end else if (w_wr_data) begin
      r_ptr <= r_ptr + INDEX_W'(1);
    end
  end

  palette_ram #(
    .ADDR_W (INDEX_W),
    .DATA_W (COLOR_W)
  ) u_ram (
    .clk      (clk),
    .i_rst_a  (rst),
    .i_we_a   (w_wr_data),
    .i_re_a   (w_rd_data),
    .i_addr_a (r_ptr),
    .i_din_a  (bus.write_data[COLOR_W-1:0]),
    .o_dout_a (w_cpu_rdata),
    .i_addr_b (bus.index_in),
    .o_dout_b (w_pix_color)
  );

  // Stage 1 sits beside the RAM output register, stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active_d1 <= 1'b0;
      r_hsync_d1  <= 1'b1;
      r_vsync_d1  <= 1'b1;
      r_active_d2 <= 1'b0;
      r_hsync_d2  <= 1'b1;
      r_vsync_d2  <= 1'b1;
      r_rgb       <= '0;
    end else begin
      r_active_d1 <= bus.active_in;
      r_hsync_d1  <= bus.hsync_in;
      r_vsync_d1  <= bus.vsync_in;
      r_active_d2 <= r_active_d1;
      r_hsync_d2  <= r_hsync_d1;
      r_vsync_d2  <= r_vsync_d1;
      r_rgb       <= r_active_d1 ? w_pix_color : '0;
    end
  end

  // read_data is either the snapshotted ptr or the held RAM port-A word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sel <= 1'b0;
      r_rd_ptr <= '0;
    end else if (w_rd_ptr) begin
      r_rd_sel <= 1'b0;
      r_rd_ptr <= r_ptr;
    end else if (w_rd_data) begin
      r_rd_sel <= 1'b1;
    end
  end

  assign bus.read_data  = r_rd_sel ? {{(CPU_W-COLOR_W){1'b0}}, w_cpu_rdata}
                                   : {{(CPU_W-INDEX_W){1'b0}}, r_rd_ptr};
  assign bus.rgb_out    = r_rgb;
  assign bus.active_out = r_active_d2;
  assign bus.hsync_out  = r_hsync_d2;
  assign bus.vsync_out  = r_vsync_d2;

endmodule

// File: doc/palette_lookup.md
# palette_lookup

Pixel-pipeline stage directly downstream of the background filler. Converts each 9-bit palette index, {5-bit palette select, 4-bit colour}, into an 8-bit RGB332 pixel for the VGA DAC. Holds a CPU-writable 512-entry colour RAM and delays the sync/blank strobes to stay aligned with the looked-up colour.

## Interface
Parameters:
- INDEX_W, 9, palette index width (512 entries)
- COLOR_W, 8, colour width, {R[2:0], G[2:0], B[1:0]}

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- index_in  in  INDEX_W  palette index from background filler
- active_in  in  1  1 = visible pixel, aligned with index_in
- hsync_in  in  1  horizontal sync, active-low, aligned with index_in
- vsync_in  in  1  vertical sync, active-low, aligned with index_in
- rgb_out  out  COLOR_W  pixel colour to DAC
- active_out  out  1  delayed active_in
- hsync_out  out  1  delayed hsync_in
- vsync_out  out  1  delayed vsync_in
- mem_enable  in  1  CPU select for this block
- mem_write  in  1  1 = write, 0 = read (qualified by mem_enable)
- mem_addr  in  1  0 = pointer register, 1 = data register
- write_data  in  16  CPU write data
- read_data  out  16  CPU read data, registered

## Operation
- Pointer register `ptr` (INDEX_W bits):
  - Write to addr 0 loads `ptr <= write_data[8:0]`.
  - Read of addr 0 returns {7'b0, ptr}.
- Data register:
  - Write to addr 1 stores write_data[7:0] into RAM[ptr], then `ptr <= ptr + 1`.
  - Read of addr 1 returns {8'b0, RAM[ptr]} and does not change ptr.
- Pointer wraps 511 -> 0 with no flag.
- Pixel path (video port): RAM read at index_in, registered, then output-registered.
  - rgb_out = colour when the delayed active is 1; otherwise 8'h00.
- CPU writes are allowed at any time, including active video. No stalls and no handshake.
- Same-cycle CPU write and pixel read of the same entry: the pixel read returns the old value (read-first). The new value is seen from the next cycle onward.
- mem_write with mem_enable = 0 is ignored.
- RAM contents are not cleared by rst. They are undefined until written.

## Timing
- Pixel latency is exactly 2 cycles: index_in at edge N gives rgb_out valid after edge N+2.
- active/hsync/vsync pass through the same 2-stage delay, so they stay cycle-aligned with rgb_out.
- CPU write takes effect at the clock edge where mem_enable & mem_write are sampled. ptr increments at that same edge.
- Back-to-back data writes on consecutive cycles fill consecutive entries.
- CPU read: read_data is valid 1 cycle after the cycle with mem_enable & !mem_write. It holds until the next read.
- Reset values (all synchronous):
  - rgb_out = 0, active_out = 0
  - hsync_out = 1, vsync_out = 1 (inactive)
  - read_data = 0, ptr = 0
  - all pipeline registers at their inactive values
- Reset mid-frame: outputs are forced to the values above on the reset edge. A pending CPU write in that same cycle is dropped and ptr stays 0. The pipeline refills 2 cycles after rst falls.

## Structure
- Shared package gpu_pkg holds:
  - INDEX_W and COLOR_W constants
  - register offsets PAL_REG_PTR = 0 and PAL_REG_DATA = 1
  - the RGB332 field positions
- One sub-module, palette_ram: 512x8 true dual-port RAM.
  - Port A: CPU read/write.
  - Port B: video read-only.
  - Both ports have synchronous, read-first reads. It maps to one block RAM.
- Top level contains only: ptr logic, register decode, the 2-stage strobe delay, blanking mux, and read_data register.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> rgb_out = 0, hsync_out = vsync_out = 1, active_out = 0, and a read of addr 0 returns 0.
- Write ptr = 0x050, then data 0xE0, 0x1C, 0x03 -> index_in 0x050/0x051/0x052 with active_in = 1 gives rgb_out 0xE0/0x1C/0x03 exactly 2 cycles later. A read of addr 0 returns 0x053.
- Blanking: active_in = 0 with index_in = 0x050 -> rgb_out = 0x00. hsync/vsync pulses appear at the outputs delayed by exactly 2 cycles.
- Wrap: ptr = 0x1FF, write 0xAA then 0x55 -> RAM[0x1FF] = 0xAA, RAM[0x000] = 0x55, and ptr reads back 0x001.
- Collision: RAM[0x075] = 0x11; write 0x22 to 0x075 while index_in = 0x075 on consecutive cycles -> the colliding pixel gives 0x11 and the following pixel gives 0x22.
- Reset mid-operation: assert rst during active video alongside a data write -> the write is not stored and ptr = 0. After release, valid pixels return 2 cycles later.
